stage0_fetch_queue: RTL and testbench

//  Fetch stage directly upstream of Stage 1 decode/regread. Owns the fetch PC, issues

---
 rtl/stage0_fetch_queue.sv | 143 ++++++++++++++
 tb/tb_stage0_fetch_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage0_fetch_queue.sv
// Fetch stage: owns the fetch PC, keeps one icache read in flight and queues {pc, inst} for decode.
// Optional FETCHQ_BYPASS_EN forwards a response straight to out_* when the queue is empty.
module stage0_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic [31:0] icache_dout,
    input  logic        icache_valid
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, WAIT, KILL} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    entry_t [DEPTH-1:0] mem_q;
    entry_t          head;

    logic resp_ok;
    logic enq;
    logic pop;

    // With a single request in flight, a free slot at issue time is always still free on return.
    assign icache_re   = reset && (state_q == FETCH) && (count_q < FULL) && !redirect;
    assign icache_addr = fetch_pc_q;
    assign resp_ok     = (state_q == WAIT) && icache_valid && !redirect;
    assign pop         = (count_q != '0) && out_ready;
    assign head        = mem_q[rd_ptr_q];

`ifdef FETCHQ_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = resp_ok && (count_q == '0);
    // A bypassed response only lands in the queue when decode is not taking it this cycle.
    assign enq        = resp_ok && !(bypass_hit && out_ready);

    always_comb begin
        out_valid = 1'b0;
        out_inst  = NOP;
        out_pc    = '0;
        if (count_q != '0) begin
            out_valid = 1'b1;
            out_inst  = head.inst;
            out_pc    = head.pc;
        end else if (bypass_hit) begin
            out_valid = 1'b1;
            out_inst  = icache_dout;
            out_pc    = req_pc_q;
        end
    end
`else
    assign enq = resp_ok;

    always_comb begin
        out_valid = 1'b0;
        out_inst  = NOP;
        out_pc    = '0;
        if (count_q != '0) begin
            out_valid = 1'b1;
            out_inst  = head.inst;
            out_pc    = head.pc;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        unique case (state_q)
            FETCH: begin
                if (icache_re) begin
                    state_d    = WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (icache_valid)  state_d = FETCH;
                else if (redirect) state_d = KILL;
            end
            KILL: begin
                if (icache_valid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (redirect) fetch_pc_d = redirect_pc;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, enq};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
        count_d  = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
        // Flush: the pop in this cycle is simply absorbed by clearing everything.
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= '{pc: req_pc_q, inst: icache_dout};
    end
endmodule

// File: tb/tb_stage0_fetch_queue.sv
// Bench for stage0_fetch_queue: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_stage0_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_2000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        redirect     = 1'b0;
    logic [31:0] redirect_pc  = '0;
    logic        out_ready    = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout  = '0;
    logic        icache_valid = 1'b0;

    stage0_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .icache_addr(icache_addr), .icache_re(icache_re),
        .icache_dout(icache_dout), .icache_valid(icache_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        mq[$];
    logic [31:0] m_fpc = RPC;
    logic [31:0] m_opc = '0;
    bit          m_out = 1'b0;
    bit          m_kill = 1'b0;
    bit          rst_lvl = 1'b0;
    int          lat = 1;
    int          rcnt = 0;
    int          cyc = 0;
    logic [31:0] raddr = '0;
    logic [31:0] strobe_log[$];
    logic [31:0] pop_log[$];
    int          strobe_cyc[$];
    bit          o_valid, o_re;
    logic [31:0] o_pc, o_addr;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic clr_logs();
        strobe_log.delete();
        strobe_cyc.delete();
        pop_log.delete();
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
        bit          e_re, e_v, byp;
        logic [31:0] e_pc, e_inst;
        ent_t        ne;
        @(negedge clk);
        reset       = rst_lvl;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        icache_valid = 1'b0;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                icache_valid = 1'b1;
                icache_dout  = memw(raddr);
            end
        end
        if (!reset) begin
            mq.delete();
            m_fpc  = RPC;
            m_out  = 1'b0;
            m_kill = 1'b0;
        end
        #1;
        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = reset && (mq.size() == 0) && m_out && !m_kill && icache_valid && !rd;
`endif
        e_re   = reset && !m_out && (mq.size() < DEPTH) && !rd;
        e_v    = (mq.size() > 0) || byp;
        e_pc   = '0;
        e_inst = NOP;
        if (mq.size() > 0) begin
            e_pc   = mq[0].pc;
            e_inst = mq[0].inst;
        end else if (byp) begin
            e_pc   = m_opc;
            e_inst = icache_dout;
        end
        checks++;
        if (icache_re !== e_re) begin
            errors++; $display("FAIL icache_re cyc %0d got %b exp %b", cyc, icache_re, e_re);
        end
        if (e_re || !reset) begin
            checks++;
            if (icache_addr !== m_fpc) begin
                errors++; $display("FAIL icache_addr cyc %0d got %h exp %h", cyc, icache_addr, m_fpc);
            end
        end
        checks++;
        if (out_valid !== e_v) begin
            errors++; $display("FAIL out_valid cyc %0d got %b exp %b", cyc, out_valid, e_v);
        end
        checks++;
        if (out_pc !== e_pc) begin
            errors++; $display("FAIL out_pc cyc %0d got %h exp %h", cyc, out_pc, e_pc);
        end
        checks++;
        if (out_inst !== e_inst) begin
            errors++; $display("FAIL out_inst cyc %0d got %h exp %h", cyc, out_inst, e_inst);
        end
        o_valid = out_valid; o_pc = out_pc; o_re = icache_re; o_addr = icache_addr;
        if (icache_re === 1'b1) begin
            strobe_log.push_back(icache_addr);
            strobe_cyc.push_back(cyc);
            rcnt  = lat;
            raddr = icache_addr;
        end
        if (out_valid === 1'b1 && rdy) pop_log.push_back(out_pc);
        if (reset) begin
            if (e_v && rdy && mq.size() > 0) ne = mq.pop_front();
            if (icache_valid && m_out) begin
                m_out = 1'b0;
                if (!m_kill && !rd && !(byp && rdy)) begin
                    ne.pc = m_opc; ne.inst = icache_dout; mq.push_back(ne);
                end
            end
            if (e_re) begin
                m_out = 1'b1; m_kill = 1'b0; m_opc = m_fpc; m_fpc = m_fpc + 32'd4;
            end
            if (rd) begin
                mq.delete(); m_fpc = rpc;
                if (m_out) m_kill = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_lvl = 1'b0;
        repeat (4) step(1'b0, '0, 1'b0);
        rst_lvl = 1'b1;
        clr_logs();
    endtask

    task automatic test_reset();
        rst_lvl = 1'b0;
        repeat (2) step(1'b0, '0, 1'b0);
        checks++; if (icache_addr !== RPC) begin errors++; $display("FAIL reset_addr got %h exp %h", icache_addr, RPC); end
        checks++; if (icache_re !== 1'b0) begin errors++; $display("FAIL reset_re got %b exp 0", icache_re); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", out_inst, NOP); end
    endtask

    task automatic test_stream();
        rst_lvl = 1'b1; clr_logs(); lat = 1;
        repeat (8) step(1'b0, '0, 1'b1);
        checks++;
        if (strobe_log.size() < 3 || pop_log.size() < 3) begin
            errors++; $display("FAIL stream_count got %0d/%0d exp >=3", strobe_log.size(), pop_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (strobe_log[i] !== RPC + 32'(4*i)) begin
                    errors++; $display("FAIL stream_addr%0d got %h exp %h", i, strobe_log[i], RPC + 32'(4*i));
                end
                checks++;
                if (pop_log[i] !== RPC + 32'(4*i)) begin
                    errors++; $display("FAIL stream_pop%0d got %h exp %h", i, pop_log[i], RPC + 32'(4*i));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (strobe_cyc[i] - strobe_cyc[i-1] != 2) begin
                    errors++; $display("FAIL stream_gap%0d got %0d exp 2", i, strobe_cyc[i] - strobe_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_full();
        do_reset(); lat = 1;
        repeat (12) step(1'b0, '0, 1'b0);
        checks++;
        if (strobe_log.size() != DEPTH) begin
            errors++; $display("FAIL full_strobes got %0d exp %0d", strobe_log.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (strobe_log[i] !== RPC + 32'(4*i)) begin
                    errors++; $display("FAIL full_addr%0d got %h exp %h", i, strobe_log[i], RPC + 32'(4*i));
                end
            end
        end
        checks++; if (o_re !== 1'b0) begin errors++; $display("FAIL full_re got %b exp 0", o_re); end
        clr_logs();
        repeat (6) step(1'b0, '0, 1'b1);
        checks++;
        if (pop_log.size() < DEPTH || strobe_log.size() < 1) begin
            errors++; $display("FAIL drain_count got %0d/%0d exp >=%0d/1", pop_log.size(), strobe_log.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (pop_log[i] !== RPC + 32'(4*i)) begin
                    errors++; $display("FAIL drain_pop%0d got %h exp %h", i, pop_log[i], RPC + 32'(4*i));
                end
            end
            checks++;
            if (strobe_log[0] !== 32'h0000_2010) begin
                errors++; $display("FAIL resume_addr got %h exp 00002010", strobe_log[0]);
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset(); lat = 3;
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_3000, 1'b1);
        clr_logs();
        for (int i = 0; i < 20 && pop_log.size() == 0; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (pop_log.size() == 0 || strobe_log.size() == 0) begin
            errors++; $display("FAIL kill_timeout got %0d pops exp >=1", pop_log.size());
        end else begin
            checks++;
            if (strobe_log[0] !== 32'h0000_3000) begin
                errors++; $display("FAIL kill_addr got %h exp 00003000", strobe_log[0]);
            end
            checks++;
            if (pop_log[0] !== 32'h0000_3000) begin
                errors++; $display("FAIL kill_pc got %h exp 00003000", pop_log[0]);
            end
        end
    endtask

    task automatic test_redirect_pop();
        do_reset(); lat = 1;
        repeat (5) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_4000, 1'b1);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rpop_valid got %b exp 1", o_valid); end
        checks++; if (o_pc !== RPC) begin errors++; $display("FAIL rpop_pc got %h exp %h", o_pc, RPC); end
        step(1'b0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rpop_flush got %b exp 0", o_valid); end
        checks++; if (o_re !== 1'b1) begin errors++; $display("FAIL rpop_re got %b exp 1", o_re); end
        checks++; if (o_addr !== 32'h0000_4000) begin errors++; $display("FAIL rpop_addr got %h exp 00004000", o_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset(); lat = 3;
        step(1'b0, '0, 1'b1);
        rst_lvl = 1'b0;
        step(1'b0, '0, 1'b1);
        checks++; if (o_re !== 1'b0) begin errors++; $display("FAIL rmid_re got %b exp 0", o_re); end
        checks++; if (o_addr !== RPC) begin errors++; $display("FAIL rmid_addr got %h exp %h", o_addr, RPC); end
        step(1'b0, '0, 1'b1);
        rst_lvl = 1'b1; clr_logs();
        for (int i = 0; i < 20 && pop_log.size() < 2; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (pop_log.size() < 2) begin
            errors++; $display("FAIL rmid_timeout got %0d pops exp 2", pop_log.size());
        end else begin
            checks++; if (strobe_log[0] !== RPC) begin errors++; $display("FAIL rmid_restart got %h exp %h", strobe_log[0], RPC); end
            checks++; if (pop_log[0] !== RPC) begin errors++; $display("FAIL rmid_pop0 got %h exp %h", pop_log[0], RPC); end
            checks++; if (pop_log[1] !== RPC + 32'd4) begin errors++; $display("FAIL rmid_pop1 got %h exp %h", pop_log[1], RPC + 32'd4); end
        end
    endtask

    task automatic test_latency();
        bit v2, v3, x2, x3;
        do_reset(); lat = 2;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1); v2 = o_valid;
        step(1'b0, '0, 1'b1); v3 = o_valid;
`ifdef FETCHQ_BYPASS_EN
        x2 = 1'b1; x3 = 1'b0;
`else
        x2 = 1'b0; x3 = 1'b1;
`endif
        checks++; if (v2 !== x2) begin errors++; $display("FAIL lat_tL got %b exp %b", v2, x2); end
        checks++; if (v3 !== x3) begin errors++; $display("FAIL lat_tL1 got %b exp %b", v3, x3); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 3);
            r   = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 19) == 0, r, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_pop();
        test_reset_mid();
        test_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
